// File: rtl/clk_prog_sender_pkg.sv
// Shared types and constants for the DCM_CLKGEN programming transmitter.
package clk_prog_sender_pkg;

   typedef enum logic [3:0] {
      IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, BLANK, WAIT_DONE, FIN
   } state_t;

   localparam logic [1:0] CMD_LOAD_D = 2'b01;
   localparam logic [1:0] CMD_LOAD_M = 2'b11;
   localparam int LOAD_BITS = 10;
   localparam int GAP_BITS  = 2;

   // Command prefix sits in the low bits so an LSB-first shift sends it first.
   function automatic logic [LOAD_BITS-1:0] load_frame(input logic [1:0] cmd,
                                                       input logic [7:0] val);
      return {val, cmd};
   endfunction

endpackage

// File: rtl/clk_prog_div.sv
// progclk generator: toggles every DIV clocks, bit_tick marks the high->low toggle.
module clk_prog_div #(
   parameter int DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   output logic progclk,
   output logic bit_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          term;

   assign term     = (cnt == CW'(DIV - 1));
   assign bit_tick = term & progclk;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt     <= '0;
         progclk <= 1'b0;
      end else if (term) begin
         cnt     <= '0;
         progclk <= ~progclk;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/clk_prog_sender.sv
// Serial programming transmitter for DCM_CLKGEN (M/D load, GO, wait for done).
// Optional WAIT_DONE timeout enabled by defining PROG_TIMEOUT_EN.
module clk_prog_sender
   import clk_prog_sender_pkg::*;
#(
   parameter int PROGCLK_DIV   = 4,
   parameter int N_TARGETS     = 4,
   parameter int BLANK_PERIODS = 4
`ifdef PROG_TIMEOUT_EN
   , parameter int TIMEOUT_PERIODS = 1024
`endif
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wr_en,
   input  logic [8:0]           m_val,
   input  logic [8:0]           d_val,
   input  logic [1:0]           target,
   output logic                 ready,
   output logic                 done,
   output logic                 err,
   output logic [N_TARGETS-1:0] progen,
   output logic                 progdata,
   output logic                 progclk,
   input  logic                 progdone_inv
);

   state_t                 state;
   logic                   bit_tick;
   logic [1:0]             done_sync;
   logic [7:0]             m_q, d_q;
   logic [1:0]             tgt_q;
   logic [7:0]             bit_cnt;
   logic [LOAD_BITS-1:0]   shreg;
   logic [LOAD_BITS-1:0]   frame_d, frame_m;
   logic [N_TARGETS-1:0]   one_hot;
   logic                   m_ok, d_ok;
`ifdef PROG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_PERIODS + 1);
   logic [TW-1:0]          to_cnt;
`endif

   clk_prog_div #(.DIV(PROGCLK_DIV)) u_div (
      .CLK      (CLK),
      .RST      (RST),
      .progclk  (progclk),
      .bit_tick (bit_tick)
   );

   assign m_ok    = (m_val >= 9'd2) && (m_val <= 9'd256);
   assign d_ok    = (d_val >= 9'd1) && (d_val <= 9'd256);
   assign frame_d = load_frame(CMD_LOAD_D, d_q);
   assign frame_m = load_frame(CMD_LOAD_M, m_q);
   assign one_hot = N_TARGETS'(1) << tgt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) done_sync <= 2'b11;
      else     done_sync <= {done_sync[0], progdone_inv};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         ready    <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
         progen   <= '0;
         progdata <= 1'b0;
         m_q      <= '0;
         d_q      <= '0;
         tgt_q    <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
`ifdef PROG_TIMEOUT_EN
         to_cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // ready=0 in IDLE means a request is armed and waits for a bit tick
               if (!ready && bit_tick) begin
                  state    <= LOAD_D;
                  progen   <= one_hot;
                  progdata <= frame_d[0];
                  shreg    <= frame_d >> 1;
                  bit_cnt  <= 8'(LOAD_BITS - 1);
               end
            end
            LOAD_D, LOAD_M: if (bit_tick) begin
               if (bit_cnt == 8'd0) begin
                  state    <= (state == LOAD_D) ? GAP1 : GAP2;
                  progen   <= '0;
                  progdata <= 1'b0;
                  bit_cnt  <= 8'(GAP_BITS - 1);
               end else begin
                  progdata <= shreg[0];
                  shreg    <= shreg >> 1;
                  bit_cnt  <= bit_cnt - 8'd1;
               end
            end
            GAP1: if (bit_tick) begin
               if (bit_cnt == 8'd0) begin
                  state    <= LOAD_M;
                  progen   <= one_hot;
                  progdata <= frame_m[0];
                  shreg    <= frame_m >> 1;
                  bit_cnt  <= 8'(LOAD_BITS - 1);
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            GAP2: if (bit_tick) begin
               if (bit_cnt == 8'd0) begin
                  state  <= GO;
                  progen <= one_hot;
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            GO: if (bit_tick) begin
               state   <= BLANK;
               progen  <= '0;
               bit_cnt <= 8'(BLANK_PERIODS - 1);
            end
            BLANK: if (bit_tick) begin
               if (bit_cnt == 8'd0) begin
                  state <= WAIT_DONE;
`ifdef PROG_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            WAIT_DONE: begin
               if (!done_sync[1]) begin
                  state <= FIN;
                  done  <= 1'b1;
                  ready <= 1'b1;
               end
`ifdef PROG_TIMEOUT_EN
               else if (bit_tick) begin
                  if (to_cnt == TW'(TIMEOUT_PERIODS - 1)) begin
                     state <= FIN;
                     done  <= 1'b1;
                     ready <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     to_cnt <= to_cnt + TW'(1);
                  end
               end
`endif
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase

         // Acceptance overrides the state update; illegal values leave ready high.
         if (wr_en && ready) begin
            state <= IDLE;
            m_q   <= 8'(m_val - 9'd1);
            d_q   <= 8'(d_val - 9'd1);
            tgt_q <= target;
            err   <= !(m_ok && d_ok);
            ready <= !(m_ok && d_ok);
         end
      end
   end

endmodule

// File: tb/tb_clk_prog_sender.sv
// Randomized self-checking bench for clk_prog_sender (bit-level stream model).
module tb_clk_prog_sender;

   localparam int DIV   = 2;
   localparam int NT    = 4;
   localparam int BLANK = 4;
   localparam int TO    = 16;
   localparam int SEQ   = 25 + BLANK;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          wr_en = 1'b0;
   logic [8:0]    m_val = '0;
   logic [8:0]    d_val = '0;
   logic [1:0]    target = '0;
   logic          progdone_inv = 1'b1;
   logic          ready, done, err, progdata, progclk;
   logic [NT-1:0] progen;

   int total = 0;
   int bad   = 0;

   clk_prog_sender #(
      .PROGCLK_DIV(DIV), .N_TARGETS(NT), .BLANK_PERIODS(BLANK)
`ifdef PROG_TIMEOUT_EN
      , .TIMEOUT_PERIODS(TO)
`endif
   ) dut (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .m_val(m_val), .d_val(d_val),
      .target(target), .ready(ready), .done(done), .err(err), .progen(progen),
      .progdata(progdata), .progclk(progclk), .progdone_inv(progdone_inv)
   );

   always #5 CLK = ~CLK;

   // Capture {progen, progdata} at every progclk rising edge; count done cycles.
   logic [NT:0] cap[$];
   logic        pc_q = 1'b0;
   int          done_cnt = 0;
   always @(negedge CLK) begin
      if (progclk && !pc_q) cap.push_back({progen, progdata});
      pc_q <= progclk;
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   // Expected bit i of a transfer, straight from the documented sequence.
   function automatic logic [NT:0] exp_bit(int i, int m, int d, int t);
      logic [NT-1:0] oh;
      logic          b;
      int            j;
      oh = NT'(1) << t;
      if (i < 10) begin
         b = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : ((((d - 1) >> (i - 2)) & 1) != 0);
         return {oh, b};
      end
      if (i < 12) return '0;
      if (i < 22) begin
         j = i - 12;
         b = (j < 2) ? 1'b1 : ((((m - 1) >> (j - 2)) & 1) != 0);
         return {oh, b};
      end
      if (i < 24) return '0;
      if (i == 24) return {oh, 1'b0};
      return '0;
   endfunction

   function automatic int first_active();
      for (int i = 0; i < cap.size(); i++)
         if (cap[i][NT:1] != '0) return i;
      return -1;
   endfunction

   task automatic check_stream(input string name, input int m, input int d, input int t);
      int idx, nbad, at;
      idx = first_active();
      nbad = 0; at = -1;
      if (idx < 0 || cap.size() < idx + SEQ) begin
         nbad = 1;
      end else begin
         for (int i = 0; i < SEQ; i++)
            if (cap[idx+i] !== exp_bit(i, m, d, t)) begin
               nbad++;
               if (at < 0) at = i;
            end
      end
      total++;
      if (nbad != 0) begin
         bad++;
         if (at >= 0)
            $display("FAIL %s stream: bit %0d got %b want %b (%0d wrong bits)",
                     name, at, cap[idx+at], exp_bit(at, m, d, t), nbad);
         else
            $display("FAIL %s stream: got %0d captured bits from %0d want %0d", name,
                     cap.size(), idx, SEQ);
      end
   endtask

   task automatic wait_done(input string name, input int d0);
      int  lat;
      bit  seen;
      progdone_inv = 1'b0;
      lat = 0; seen = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done === 1'b1) begin lat = k; seen = 1; break; end
      end
      total++;
      if (!seen || lat < 2 || lat > 3) begin
         bad++;
         $display("FAIL %s done latency: got %0d (seen=%0d) want 2..3", name, lat, seen);
      end
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready after done: got %b want 1", name, ready);
      end
      repeat (6) tick();
      progdone_inv = 1'b1;
      total++;
      if (done_cnt != d0 + 1) begin
         bad++;
         $display("FAIL %s done pulses: got %0d want 1", name, done_cnt - d0);
      end
   endtask

   task automatic run_transfer(input string name, input int m, input int d, input int t,
                               input bit hold);
      int d0;
      cap.delete();
      d0 = done_cnt;
      m_val = 9'(m); d_val = 9'(d); target = 2'(t); wr_en = 1'b1;
      tick();
      if (!hold) wr_en = 1'b0;
      total++;
      if (ready !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL %s accept: ready=%b err=%b want ready=0 err=0", name, ready, err);
      end
      for (int c = 0; c < 150; c++) begin
         if (hold) begin
            m_val = 9'($urandom_range(256, 2));
            d_val = 9'($urandom_range(256, 1));
            target = 2'($urandom_range(3, 0));
         end
         tick();
      end
      wr_en = 1'b0;
      total++;
      if (done_cnt != d0) begin
         bad++;
         $display("FAIL %s early done: got %0d pulses want 0", name, done_cnt - d0);
      end
      check_stream(name, m, d, t);
      wait_done(name, d0);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      total++;
      if ({ready, done, err, progen, progdata, progclk} !== {3'b100, {NT{1'b0}}, 2'b00}) begin
         bad++;
         $display("FAIL reset values: ready=%b done=%b err=%b progen=%b data=%b pclk=%b want 1 0 0 0 0 0",
                  ready, done, err, progen, progdata, progclk);
      end
      RST = 1'b0;
      repeat (5) tick();
      total++;
      if (ready !== 1'b1 || progen !== '0 || done !== 1'b0) begin
         bad++;
         $display("FAIL post-reset idle: ready=%b progen=%b done=%b want 1 0 0", ready, progen, done);
      end
   endtask

   task automatic test_basic();
      run_transfer("basic", 10, 4, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++)
         run_transfer("random", int'($urandom_range(256, 2)), int'($urandom_range(256, 1)),
                      int'($urandom_range(3, 0)), 1'b0);
   endtask

   task automatic test_range_err();
      int ms[6] = '{1, 0, 300, 5, 9, 511};
      int ds[6] = '{5, 7, 4, 0, 257, 1};
      cap.delete();
      for (int i = 0; i < 6; i++) begin
         m_val = 9'(ms[i]); d_val = 9'(ds[i]); target = 2'(i % 4); wr_en = 1'b1;
         tick();
         wr_en = 1'b0;
         total++;
         if (err !== 1'b1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL range M=%0d D=%0d: err=%b ready=%b want 1 1", ms[i], ds[i], err, ready);
         end
         repeat (3) tick();
      end
      repeat (40) tick();
      total++;
      if (first_active() != -1 || err !== 1'b1) begin
         bad++;
         $display("FAIL range no transfer: active at %0d err=%b want -1 1", first_active(), err);
      end
      run_transfer("min", 2, 1, 1, 1'b0);
   endtask

   task automatic test_max();
      run_transfer("max", 256, 256, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_transfer("held", int'($urandom_range(256, 2)), int'($urandom_range(256, 1)), 2, 1'b1);
   endtask

   task automatic test_reset_mid();
      bit seen;
      cap.delete();
      m_val = 9'd77; d_val = 9'd33; target = 2'd1; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (progen !== '0) begin seen = 1; break; end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL midreset start: progen got 0 want active within 40 cycles");
      end
      repeat (14 * 2 * DIV) tick();
      RST = 1'b1;
      #1;
      total++;
      if (progen !== '0 || progclk !== 1'b0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL midreset abort: progen=%b progclk=%b ready=%b want 0 0 1", progen, progclk, ready);
      end
      repeat (2) tick();
      RST = 1'b0;
      tick();
      run_transfer("after_reset", int'($urandom_range(256, 2)), int'($urandom_range(256, 1)), 3, 1'b0);
   endtask

`ifdef PROG_TIMEOUT_EN
   task automatic test_timeout();
      int  d0, idx, n;
      bit  seen;
      cap.delete();
      d0 = done_cnt;
      m_val = 9'd20; d_val = 9'd3; target = 2'd0; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      seen = 0;
      for (int c = 0; c < 600; c++) begin
         tick();
         if (done === 1'b1) begin seen = 1; break; end
      end
      idx = first_active();
      n = (idx < 0) ? -1 : cap.size() - idx;
      total++;
      if (!seen || n < 44 || n > 46) begin
         bad++;
         $display("FAIL timeout timing: seen=%0d bits since start=%0d want 44..46", seen, n);
      end
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL timeout err: got %b want 1", err);
      end
      repeat (4) tick();
      total++;
      if (done_cnt != d0 + 1 || ready !== 1'b1) begin
         bad++;
         $display("FAIL timeout pulse: pulses=%0d ready=%b want 1 1", done_cnt - d0, ready);
      end
      run_transfer("post_timeout", 40, 40, 2, 1'b0);
   endtask
`else
   task automatic test_timeout();
      int d0;
      cap.delete();
      d0 = done_cnt;
      m_val = 9'd20; d_val = 9'd3; target = 2'd0; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      repeat (600) tick();
      total++;
      if (done_cnt != d0 || err !== 1'b0 || ready !== 1'b0) begin
         bad++;
         $display("FAIL no-timeout wait: pulses=%0d err=%b ready=%b want 0 0 0",
                  done_cnt - d0, err, ready);
      end
      wait_done("no_timeout", d0);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_range_err();
      test_max();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
